parking_request_dispatcher: RTL

//  Upstream of the elevator controller. Captures 1-cycle in_mode/out_mode pulses with license_plate,

---
 rtl/parking_pkg.sv | 54 +++++
 rtl/parking_request_fifo.sv | 41 ++++
 rtl/parking_request_dispatcher.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking request dispatcher: slot classes, slot
// index mapping, plate decode and the slot search helpers.
package parking_pkg;

  localparam int NUM_SLOTS = 14;

  // Slot index = (floor-1)*2 + place, so ascending index is the allocation order.
  localparam logic [NUM_SLOTS-1:0] DIS_MASK   = 14'h0005;
  localparam logic [NUM_SLOTS-1:0] SUV_MASK   = 14'h3332;
  localparam logic [NUM_SLOTS-1:0] SEDAN_MASK = 14'h0CC8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PICK      = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  function automatic logic [2:0] slot_floor(input logic [3:0] idx);
    return idx[3:1] + 3'd1;
  endfunction

  function automatic logic slot_place(input logic [3:0] idx);
    return idx[0];
  endfunction

  function automatic logic is_disabled(input logic [15:0] plate);
    return plate[15:12] == 4'b1001;
  endfunction

  function automatic logic is_suv(input logic [15:0] plate);
    return plate[11];
  endfunction

  // Returns {hit, index} of the lowest set bit.
  function automatic logic [4:0] pick_lowest(input logic [NUM_SLOTS-1:0] vec);
    pick_lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (vec[i]) pick_lowest = {1'b1, 4'(i)};
  endfunction

  function automatic logic [NUM_SLOTS-1:0] leak_mask(input logic en, input logic [2:0] floor);
    leak_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (en && floor != 3'd0 && slot_floor(4'(i)) == floor) leak_mask[i] = 1'b1;
  endfunction

  function automatic logic [3:0] popcount14(input logic [NUM_SLOTS-1:0] vec);
    popcount14 = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      popcount14 = popcount14 + {3'b000, vec[i]};
  endfunction

endpackage

// File: rtl/parking_request_fifo.sv
// Show-ahead request queue holding license plates; pushes into a full queue
// and pops from an empty queue are ignored.
module request_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/parking_request_dispatcher.sv
// Queues entry/exit requests, allocates or looks up a slot in the occupancy
// map and hands one command at a time to the elevator.
//   state     | meaning
//   IDLE      | wait for a queued request (exit queue first)
//   PICK      | search free slot (entry) or plate (exit)
//   ISSUE     | cmd_valid high until elevator accepts
//   WAIT_DONE | wait for elevator cmd_done
module parking_request_dispatcher
  import parking_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PLATE_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_mode,
  input  logic               out_mode,
  input  logic [PLATE_W-1:0] license_plate,
  input  logic               leakage,
  input  logic [2:0]         leakage_floor,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_dir,
  output logic [2:0]         cmd_floor,
  output logic               cmd_place,
  output logic [PLATE_W-1:0] cmd_plate,
  input  logic               cmd_done,
  output logic               reject,
  output logic               not_found,
  output logic               overflow,
  output logic [3:0]         empty_suv,
  output logic [3:0]         empty_sedan,
  output logic               full_suv,
  output logic               full_sedan
);

  state_t state, state_nxt;

  logic               ent_full, ent_empty, ent_pop;
  logic               ext_full, ext_empty, ext_pop;
  logic [PLATE_W-1:0] ent_head, ext_head;

  logic               req_dir;
  logic [PLATE_W-1:0] req_plate;
  logic [3:0]         slot;
  logic [NUM_SLOTS-1:0] occ;
  logic [PLATE_W-1:0] plate_map [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] avail, class_mask, match;
  logic [4:0]           dis_hit, cls_hit, entry_hit, exit_hit, pick_res;

  request_fifo #(.WIDTH(PLATE_W), .DEPTH(FIFO_DEPTH)) u_entry_q (
    .clock(clock), .reset(reset), .push(in_mode), .din(license_plate),
    .pop(ent_pop), .dout(ent_head), .full(ent_full), .empty(ent_empty)
  );

  request_fifo #(.WIDTH(PLATE_W), .DEPTH(FIFO_DEPTH)) u_exit_q (
    .clock(clock), .reset(reset), .push(out_mode), .din(license_plate),
    .pop(ext_pop), .dout(ext_head), .full(ext_full), .empty(ext_empty)
  );

  // Disabled plates try the two disabled slots before their own size class.
  assign avail      = ~occ & ~leak_mask(leakage, leakage_floor);
  assign class_mask = is_suv(req_plate[15:0]) ? SUV_MASK : SEDAN_MASK;
  assign dis_hit    = pick_lowest(avail & DIS_MASK);
  assign cls_hit    = pick_lowest(avail & class_mask);
  assign entry_hit  = (is_disabled(req_plate[15:0]) && dis_hit[4]) ? dis_hit : cls_hit;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      match[i] = occ[i] && (plate_map[i] == req_plate);
  end

  assign exit_hit = pick_lowest(match);
  assign pick_res = req_dir ? exit_hit : entry_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ent_pop   = 1'b0;
    ext_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!ext_empty) begin
          ext_pop   = 1'b1;
          state_nxt = PICK;
        end else if (!ent_empty) begin
          ent_pop   = 1'b1;
          state_nxt = PICK;
        end
      end
      PICK:      state_nxt = pick_res[4] ? ISSUE : IDLE;
      ISSUE:     if (cmd_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (cmd_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign cmd_valid = (state == ISSUE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_dir   <= 1'b0;
      req_plate <= '0;
      slot      <= '0;
      occ       <= '0;
      cmd_dir   <= 1'b0;
      cmd_floor <= '0;
      cmd_place <= 1'b0;
      cmd_plate <= '0;
      reject    <= 1'b0;
      not_found <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      reject    <= 1'b0;
      not_found <= 1'b0;
      overflow  <= (in_mode && ent_full) || (out_mode && ext_full);
      if (ext_pop) begin
        req_dir   <= 1'b1;
        req_plate <= ext_head;
      end else if (ent_pop) begin
        req_dir   <= 1'b0;
        req_plate <= ent_head;
      end
      if (state == PICK) begin
        if (pick_res[4]) begin
          slot      <= pick_res[3:0];
          cmd_dir   <= req_dir;
          cmd_floor <= slot_floor(pick_res[3:0]);
          cmd_place <= slot_place(pick_res[3:0]);
          cmd_plate <= req_plate;
        end else if (req_dir) begin
          not_found <= 1'b1;
        end else begin
          reject    <= 1'b1;
        end
      end
      // Entry reserves its slot at hand-off; exit releases only once the car is out.
      if (state == ISSUE && cmd_ready && !req_dir) occ[slot] <= 1'b1;
      if (state == WAIT_DONE && cmd_done && req_dir) occ[slot] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (state == ISSUE && cmd_ready && !req_dir) plate_map[slot] <= req_plate;
  end

  assign empty_suv   = popcount14(~occ & SUV_MASK);
  assign empty_sedan = popcount14(~occ & SEDAN_MASK);
  assign full_suv    = (empty_suv == 4'd0);
  assign full_sedan  = (empty_sedan == 4'd0);

endmodule
